// File: rtl/hyper_trans_arbiter.sv
// Round-robin arbiter sharing the hyperbus transaction engine between NB_CH uDMA channels.
// Latency: grant pulse and owner ID one cycle after an eligible request is seen in IDLE.
// Backpressure: ownership is held until done_i; request/enable changes are ignored meanwhile.
module hyper_trans_arbiter #(
  parameter int NB_CH    = 8,
  parameter int ID_WIDTH = $clog2(NB_CH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NB_CH-1:0]    req_i,
  input  logic [NB_CH-1:0]    ch_en_i,
  input  logic                done_i,
  output logic [NB_CH-1:0]    gnt_o,
  output logic [ID_WIDTH-1:0] gnt_id_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam logic [NB_CH-1:0]  GNT_ONE = {{(NB_CH-1){1'b0}}, 1'b1};
  localparam logic [ID_WIDTH:0] NB_CH_W = (ID_WIDTH+1)'(NB_CH);
  localparam logic [ID_WIDTH-1:0] LAST_CH = ID_WIDTH'(NB_CH - 1);

  state_t              state_q;
  logic [ID_WIDTH-1:0] ptr_q;
  logic [NB_CH-1:0]    gnt_q;
  logic [ID_WIDTH-1:0] gnt_id_q;
  logic                busy_q;

  logic [NB_CH-1:0]    elig;
  logic [NB_CH-1:0]    rot;
  logic [ID_WIDTH:0]   sum;
  logic                found_d;
  logic [ID_WIDTH-1:0] win_d;

  // Eligible channels, rotated so that bit 0 corresponds to the channel at ptr.
  assign elig = req_i & ch_en_i;
  assign rot  = (elig >> ptr_q) | (elig << (NB_CH - int'(ptr_q)));

  // Winner: first eligible channel at or above ptr, wrapping explicitly at NB_CH.
  always_comb begin
    found_d = 1'b0;
    sum     = '0;
    for (int k = 0; k < NB_CH; k++) begin
      if (!found_d && rot[k]) begin
        found_d = 1'b1;
        sum     = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      end
    end
    if (sum >= NB_CH_W) begin
      sum = sum - NB_CH_W;
    end
    win_d = sum[ID_WIDTH-1:0];
  end

  // Arbitration FSM with registered grant, owner ID and busy outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q  <= S_GRANT;
            gnt_q    <= GNT_ONE << win_d;
            gnt_id_q <= win_d;
            busy_q   <= 1'b1;
          end else begin
            gnt_q <= '0;
          end
        end
        S_GRANT: begin
          gnt_q <= '0;
          ptr_q <= (gnt_id_q == LAST_CH) ? '0 : gnt_id_q + 1'b1;
          if (done_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          gnt_q <= '0;
          if (done_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign busy_o   = busy_q;

`ifndef SYNTHESIS
  // Grant is at most one-hot, only present in GRANT, and agrees with the binary ID.
  a_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  a_gnt_state: assert property (@(posedge clk_i) disable iff (rst_i)
    (|gnt_q) |-> (state_q == S_GRANT));
  a_gnt_id: assert property (@(posedge clk_i) disable iff (rst_i)
    (|gnt_q) |-> gnt_q[gnt_id_q]);
`endif

endmodule

// File: tb/tb_hyper_trans_arbiter.sv
// Self-checking bench for hyper_trans_arbiter (NB_CH=8 main instance, NB_CH=5 wrap instance).
// Directed vector table, hand-written corner sequences, then random stimulus vs a queue-free model.
// Inputs change 1ns after the rising edge; outputs are checked 1ns after the next rising edge.
module tb_hyper_trans_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] req_i = '0;
  logic [7:0] ch_en_i = '0;
  logic       done_i = 1'b0;
  logic [7:0] gnt_o;
  logic [2:0] gnt_id_o;
  logic       busy_o;

  logic [4:0] req5 = '0;
  logic [4:0] en5 = '0;
  logic       done5 = 1'b0;
  logic [4:0] gnt5;
  logic [2:0] id5;
  logic       busy5;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hyper_trans_arbiter #(.NB_CH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ch_en_i(ch_en_i),
    .done_i(done_i), .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .busy_o(busy_o)
  );

  hyper_trans_arbiter #(.NB_CH(5)) dut5 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req5), .ch_en_i(en5),
    .done_i(done5), .gnt_o(gnt5), .gnt_id_o(id5), .busy_o(busy5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] en;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl[19];

  // Reference model: owner flag, pointer and last owner as plain integers.
  bit         m_busy;
  int         m_ptr;
  int         m_id;
  logic [7:0] m_gnt;

  task automatic model_step(input logic [7:0] req, input logic [7:0] en, input logic done);
    logic [7:0] elig;
    bit found;
    int c;
    m_gnt = '0;
    if (m_busy) begin
      if (done) m_busy = 1'b0;
    end else begin
      elig  = req & en;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        c = (m_ptr + k) % 8;
        if (!found && elig[3'(c)]) begin
          found  = 1'b1;
          m_id   = c;
          m_gnt  = 8'd1 << c;
          m_busy = 1'b1;
          m_ptr  = (c + 1) % 8;
        end
      end
    end
  endtask

  initial begin
    // req, en, done -> gnt, id, busy (state after the edge that samples the row)
    tbl[0]  = '{8'h08, 8'hFF, 1'b0, 8'h08, 3'd3, 1'b1};
    tbl[1]  = '{8'h00, 8'hFF, 1'b0, 8'h00, 3'd3, 1'b1};
    tbl[2]  = '{8'h00, 8'hFF, 1'b0, 8'h00, 3'd3, 1'b1};
    tbl[3]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[4]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[5]  = '{8'h81, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1};
    tbl[6]  = '{8'h81, 8'hFF, 1'b1, 8'h00, 3'd7, 1'b0};
    tbl[7]  = '{8'h81, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1};
    tbl[8]  = '{8'h81, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[9]  = '{8'h81, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1};
    tbl[10] = '{8'h00, 8'hFF, 1'b1, 8'h00, 3'd7, 1'b0};
    tbl[11] = '{8'h0C, 8'hF7, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[12] = '{8'h0C, 8'hF3, 1'b0, 8'h00, 3'd2, 1'b1};
    tbl[13] = '{8'h0C, 8'hF3, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[14] = '{8'h0C, 8'hF3, 1'b0, 8'h00, 3'd2, 1'b0};
    tbl[15] = '{8'h0C, 8'hF7, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[16] = '{8'h0C, 8'hF7, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[17] = '{8'h0C, 8'hF7, 1'b0, 8'h04, 3'd2, 1'b1};
    tbl[18] = '{8'h00, 8'hFF, 1'b1, 8'h00, 3'd2, 1'b0};

    // Reset values while reset is held.
    #1;
    chk("reset_gnt", 32'(gnt_o), 32'h0);
    chk("reset_id", 32'(gnt_id_o), 32'h0);
    chk("reset_busy", 32'(busy_o), 32'h0);
    do_reset();

    // No requests: stays idle.
    ch_en_i = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_gnt", 32'(gnt_o), 32'h0);
      chk("idle_id", 32'(gnt_id_o), 32'h0);
      chk("idle_busy", 32'(busy_o), 32'h0);
    end

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      req_i   = tbl[i].req;
      ch_en_i = tbl[i].en;
      done_i  = tbl[i].done;
      tick();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_id", i), 32'(gnt_id_o), 32'(tbl[i].id));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
    end
    req_i = '0;
    done_i = 1'b0;

    // NB_CH=5: all requesting, done held high so each GRANT ends straight in IDLE.
    req5 = 5'h1F;
    en5 = 5'h1F;
    done5 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c % 2 == 0) begin
        chk("nb5_gnt", 32'(gnt5), 32'(5'd1 << ((c / 2) % 5)));
        chk("nb5_id", 32'(id5), 32'((c / 2) % 5));
        chk("nb5_busy", 32'(busy5), 32'h1);
      end else begin
        chk("nb5_gap_gnt", 32'(gnt5), 32'h0);
        chk("nb5_gap_busy", 32'(busy5), 32'h0);
      end
    end
    req5 = '0;
    done5 = 1'b0;

    // Fairness from reset: all eligible, done one cycle after each grant.
    do_reset();
    req_i = 8'hFF;
    ch_en_i = 8'hFF;
    for (int g = 0; g < 10; g++) begin
      done_i = 1'b0;
      tick();
      chk("fair_gnt", 32'(gnt_o), 32'(8'd1 << (g % 8)));
      chk("fair_id", 32'(gnt_id_o), 32'(g % 8));
      tick();
      chk("fair_busy", 32'(busy_o), 32'h1);
      done_i = 1'b1;
      tick();
      chk("fair_done", 32'(busy_o), 32'h0);
    end
    done_i = 1'b0;

    // Reset asserted mid-transaction clears state asynchronously.
    req_i = 8'h08;
    tick();
    chk("prerst_gnt", 32'(gnt_o), 32'h08);
    req_i = 8'h00;
    tick();
    chk("prerst_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy_o), 32'h0);
    chk("async_rst_id", 32'(gnt_id_o), 32'h0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_gnt", 32'(gnt_o), 32'h0);
      chk("postrst_busy", 32'(busy_o), 32'h0);
    end

    // Random traffic against the reference model (starts from IDLE, ptr=0).
    m_busy = 1'b0;
    m_ptr = 0;
    m_id = 0;
    m_gnt = '0;
    for (int i = 0; i < 600; i++) begin
      req_i   = 8'($urandom);
      ch_en_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      done_i  = ($urandom_range(0, 2) == 0);
      @(posedge clk_i);
      model_step(req_i, ch_en_i, done_i);
      #1;
      chk("rnd_gnt", 32'(gnt_o), 32'(m_gnt));
      chk("rnd_id", 32'(gnt_id_o), 32'(m_id));
      chk("rnd_busy", 32'(busy_o), 32'(m_busy));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
